// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared types and line-level constants for the serial frame receiver.
// Optional feature macro: SERIAL_RX_PARITY_EN adds the parity state.
package serial_rx_pkg;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StStop   = 2'd2,
        StParity = 2'd3
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StStop = 2'd2
    } rx_state_e;
`endif

endpackage

// File: rtl/serial_rx_shreg.sv
// serial_rx_shreg: LSB-first payload shift register.
// Ports:
//   clk_i      - clock
//   clr_i      - synchronous clear (wins over shift)
//   shift_en_i - shift bit_i in at the MSB end
//   bit_i      - serial input bit
//   data_o     - parallel payload; first received bit ends up in bit 0
module serial_rx_shreg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (shift_en_i) begin
            data_d = {bit_i, data_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives frames of start(1), DATA_W data bits LSB first,
// [even parity], stop(0) from a line that idles at 0. One bit per Clk.
// Optional feature macro: SERIAL_RX_PARITY_EN (parity state and ParityErr port).
// Ports:
//   Clk        - clock, all state on rising edge
//   Reset      - synchronous active-high reset
//   SerialIn   - serial bit stream
//   DataOut    - last good payload
//   DataValid  - one-cycle pulse when DataOut updates
//   FrameErr   - one-cycle pulse on a bad stop bit
//   ParityErr  - one-cycle pulse on parity mismatch (macro only)
//   Busy       - high while not idle
//   FrameCount - good-frame counter, wraps silently
module serial_frame_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SerialIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    output logic              FrameErr,
`ifdef SERIAL_RX_PARITY_EN
    output logic              ParityErr,
`endif
    output logic              Busy,
    output logic [CNT_W-1:0]  FrameCount
);

    localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e          state_d, state_q;
    logic [BitCntW-1:0] bit_cnt_d, bit_cnt_q;
    logic [DATA_W-1:0]  data_out_d, data_out_q;
    logic               data_valid_d, data_valid_q;
    logic               frame_err_d, frame_err_q;
    logic [CNT_W-1:0]   frame_count_d, frame_count_q;
    logic               shift_en;
    logic [DATA_W-1:0]  payload;
    logic               stop_ok;
    logic               parity_ok;
`ifdef SERIAL_RX_PARITY_EN
    logic               parity_d, parity_q;
    logic               parity_err_d, parity_err_q;
`endif

    serial_rx_shreg #(
        .Width (DATA_W)
    ) u_shreg (
        .clk_i      (Clk),
        .clr_i      (Reset),
        .shift_en_i (shift_en),
        .bit_i      (SerialIn),
        .data_o     (payload)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        shift_en      = 1'b0;
        stop_ok       = (SerialIn == STOP_BIT);
`ifdef SERIAL_RX_PARITY_EN
        parity_d      = parity_q;
        parity_err_d  = 1'b0;
        // Even parity: data bits plus parity bit must hold an even number of ones.
        parity_ok     = ((^payload) == parity_q);
`else
        parity_ok     = 1'b1;
`endif

        unique case (state_q)
            StIdle: begin
                if (SerialIn == START_BIT) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                shift_en  = 1'b1;
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            StParity: begin
                parity_d = SerialIn;
                state_d  = StStop;
            end
`endif
            StStop: begin
                // Always back to idle: a stop bit of 1 is an error, never a new start.
                state_d     = StIdle;
                frame_err_d = !stop_ok;
`ifdef SERIAL_RX_PARITY_EN
                parity_err_d = !parity_ok;
`endif
                if (stop_ok && parity_ok) begin
                    data_out_d    = payload;
                    data_valid_d  = 1'b1;
                    frame_count_d = frame_count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
`ifdef SERIAL_RX_PARITY_EN
            parity_q      <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
`ifdef SERIAL_RX_PARITY_EN
            parity_q      <= parity_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign DataOut    = data_out_q;
    assign DataValid  = data_valid_q;
    assign FrameErr   = frame_err_q;
    assign FrameCount = frame_count_q;
    assign Busy       = (state_q != StIdle);
`ifdef SERIAL_RX_PARITY_EN
    assign ParityErr  = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed self-checking bench for serial_frame_rx.
module tb_serial_frame_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int unsigned FL = DW + 3;
`else
    localparam int unsigned FL = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          serial_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    logic [CW-1:0] frame_count;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`else
    logic          parity_err = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int consec = 0;
    int valid_at[$];
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_perr = 1'b0;

    serial_frame_rx #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .Clk        (clk),
        .Reset      (reset),
        .SerialIn   (serial_in),
        .DataOut    (data_out),
        .DataValid  (data_valid),
        .FrameErr   (frame_err),
`ifdef SERIAL_RX_PARITY_EN
        .ParityErr  (parity_err),
`endif
        .Busy       (busy),
        .FrameCount (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit for one edge, then sample #1 after the edge and log pulses.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
        cyc++;
        if (data_valid === 1'b1) begin
            valid_cnt++;
            valid_at.push_back(cyc);
        end
        if (frame_err === 1'b1 || parity_err === 1'b1) err_cnt++;
        if ((data_valid && prev_valid) || (frame_err && prev_ferr) || (parity_err && prev_perr))
            consec++;
        prev_valid = data_valid;
        prev_ferr  = frame_err;
        prev_perr  = parity_err;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par_flip);
        send_bit(1'b1);
        for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) begin
        end
`endif
        send_bit(stop);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        serial_in = 1'b1;  // reset must win over a start bit
        send_bit(1'b1);
        reset = 1'b0;
        serial_in = 1'b0;
        valid_cnt = 0;
        err_cnt = 0;
        valid_at.delete();
    endtask

    initial begin
        logic [9:0] seq;

        // Reset state
        do_reset();
        check("rst_dataout", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_count", frame_count, 0);
        check("rst_perr", parity_err, 0);

        // Idle zeros keep the receiver idle
        send_bit(1'b0);
        send_bit(1'b0);
        check("idle_busy", busy, 0);
        do_reset();

        // Frame 0xA5: DataValid on edge 10 after reset
`ifndef SERIAL_RX_PARITY_EN
        seq = 10'b0101001011;  // bit 0 sent first: 1,1,0,1,0,0,1,0,1,0
        for (int i = 0; i < 9; i++) begin
            send_bit(seq[i]);
            if (i == 0) check("a5_busy_start", busy, 1);
        end
        check("a5_valid_edge9", data_valid, 0);
        send_bit(seq[9]);
`else
        seq = '0;
        send_frame(8'hA5, 1'b0, 1'b0);
`endif
        check("a5_valid_edge10", data_valid, 1);
        check("a5_dataout", data_out, 32'hA5);
        check("a5_count", frame_count, 1);
        check("a5_ferr", frame_err, 0);
        send_bit(1'b0);
        check("a5_valid_drop", data_valid, 0);
        check("a5_busy_after", busy, 0);

        // Back-to-back 0x3C, 0xFF
        do_reset();
        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        check("b2b_pulses", valid_cnt, 2);
        if (valid_at.size() == 2) check("b2b_spacing", valid_at[1] - valid_at[0], FL);
        else check("b2b_spacing_n", valid_at.size(), 2);
        check("b2b_count", frame_count, 2);
        check("b2b_dataout", data_out, 32'hFF);

        // Good 0x12 then 0x55 with bad stop bit
        do_reset();
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        check("bad_stop_ferr", frame_err, 1);
        check("bad_stop_valid", data_valid, 0);
        check("bad_stop_dataout", data_out, 32'h12);
        check("bad_stop_count", frame_count, 1);
        check("bad_stop_not_start", busy, 0);
        send_bit(1'b0);
        check("bad_stop_busy_next", busy, 0);
        check("bad_stop_ferr_drop", frame_err, 0);

        // Reset after 4th data bit discards the partial frame
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        send_bit(1'b0);
        reset = 1'b0;
        check("mid_busy", busy, 0);
        send_bit(1'b0);
        check("mid_no_valid", valid_cnt, 0);
        check("mid_no_err", err_cnt, 0);
        send_frame(8'h81, 1'b0, 1'b0);
        check("mid_dataout", data_out, 32'h81);
        check("mid_count", frame_count, 1);

`ifdef SERIAL_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1
        do_reset();
        send_frame(8'h07, 1'b0, 1'b0);
        check("par_ok_valid", data_valid, 1);
        check("par_ok_perr", parity_err, 0);
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_bad_perr", parity_err, 1);
        check("par_bad_valid", data_valid, 0);
        check("par_bad_dataout", data_out, 32'h07);
        check("par_bad_count", frame_count, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        check("par_both_perr", parity_err, 1);
        check("par_both_ferr", frame_err, 1);
`endif

        // 256 back-to-back good frames wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(DW'(i), 1'b0, 1'b0);
            if (i == 254) check("wrap_count_255", frame_count, 255);
        end
        check("wrap_count_0", frame_count, 0);
        check("wrap_pulses", valid_cnt, 256);
        check("wrap_no_err", err_cnt, 0);
        check("wrap_dataout", data_out, 32'hFF);

        check("no_consecutive_pulses", consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
